// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller.
//   - memState_e : controller FSM states
//   - *_DEF      : default datapath / address / register widths
//   - NOP_CTRL   : control fields written into MEM/WB on a bubble
package mem_stage_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned REG_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memState_e;

  typedef struct packed {
    logic we;
    logic hlt;
  } wbCtrl_t;

  localparam wbCtrl_t NOP_CTRL = '{we: 1'b0, hlt: 1'b0};

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory access.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at zero (has priority over en)
//   en         : advance the count by one
//   expired    : count has reached TIMEOUT-1
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs multi-cycle data-memory accesses over a
// req/ack handshake, stalls EX/MEM and upstream while an access is
// outstanding, and owns the MEM/WB pipeline register.
//   EX/MEM in : dst_addrIn, weIn, mem_weIn, mem_reIn, hltIn, aluResultIn, mem_dataIn
//   memory    : mem_req, mem_wr, mem_addr, mem_wdata (out); mem_rdata, mem_ack (in)
//   pipeline  : stallMEM (out, drives stallEX)
//   MEM/WB out: wb_dataOut, dst_addrOut, weOut, hltOut
//   status    : mem_errOut, sticky access-timeout flag
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned REG_W   = REG_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  dst_addrIn,
  input  logic              weIn,
  input  logic              mem_weIn,
  input  logic              mem_reIn,
  input  logic              hltIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stallMEM,
  output logic [DATA_W-1:0] wb_dataOut,
  output logic [REG_W-1:0]  dst_addrOut,
  output logic              weOut,
  output logic              hltOut,
  output logic              mem_errOut
);

  memState_e         state;
  logic [DATA_W-1:0] rdBuf;
  logic              memop;
  logic              expired;

  assign memop = mem_reIn | mem_weIn;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state == IDLE) && memop),
    .en      (state == ACCESS),
    .expired (expired)
  );

  // Stall must rise in the same cycle a memory op is seen in IDLE, so it is
  // decoded from state rather than registered; gated by rst_n so it is low
  // throughout reset even while EX/MEM still presents a memory op.
  assign stallMEM = rst_n & (((state == IDLE) & memop) | (state == ACCESS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdBuf       <= '0;
      wb_dataOut  <= '0;
      dst_addrOut <= '0;
      weOut       <= 1'b0;
      hltOut      <= 1'b0;
      mem_errOut  <= 1'b0;
    end else begin
      // Bubble by default; wb_dataOut holds unless an instruction loads.
      dst_addrOut <= '0;
      weOut       <= NOP_CTRL.we;
      hltOut      <= NOP_CTRL.hlt;
      case (state)
        IDLE: begin
          if (memop) begin
            mem_addr  <= ADDR_W'(aluResultIn);
            mem_wdata <= mem_dataIn;
            mem_wr    <= mem_weIn;
            mem_req   <= 1'b1;
            state     <= ACCESS;
          end else begin
            wb_dataOut  <= aluResultIn;
            dst_addrOut <= dst_addrIn;
            weOut       <= weIn;
            hltOut      <= hltIn;
          end
        end
        ACCESS: begin
          // An ack coinciding with expiry completes normally.
          if (mem_ack) begin
            rdBuf   <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (expired) begin
            rdBuf      <= '0;
            mem_errOut <= 1'b1;
            mem_req    <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          wb_dataOut  <= mem_wr ? aluResultIn : rdBuf;
          dst_addrOut <= dst_addrIn;
          weOut       <= weIn;
          hltOut      <= hltIn;
          state       <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a driver issues instructions and
// pushes expected MEM/WB results (data, fields, error flag, arrival cycle);
// a monitor pops and compares whenever weOut is seen; a memory responder
// checks the port and acks after a chosen number of wait cycles.
module tb_mem_stage_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned TO = 15;
  localparam int unsigned NEVER = TO + 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] dst_addrIn = '0;
  logic          weIn = 1'b0, mem_weIn = 1'b0, mem_reIn = 1'b0, hltIn = 1'b0;
  logic [DW-1:0] aluResultIn = '0, mem_dataIn = '0, mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_wr, stallMEM, weOut, hltOut, mem_errOut;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, wb_dataOut;
  logic [RW-1:0] dst_addrOut;

  mem_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .dst_addrIn(dst_addrIn), .weIn(weIn),
    .mem_weIn(mem_weIn), .mem_reIn(mem_reIn), .hltIn(hltIn),
    .aluResultIn(aluResultIn), .mem_dataIn(mem_dataIn), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .stallMEM(stallMEM), .wb_dataOut(wb_dataOut),
    .dst_addrOut(dst_addrOut), .weOut(weOut), .hltOut(hltOut),
    .mem_errOut(mem_errOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [RW-1:0] dst;
    logic          hlt;
    logic          err;
    int unsigned   cyc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    int unsigned   waitCyc;
  } acc_t;

  exp_t sbQ[$];
  acc_t accQ[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        refErr = 1'b0;
  logic [DW-1:0] refMem[16];
  logic [DW-1:0] devMem[16];
  int unsigned expStall = 0, expReq = 0, seenStall = 0, seenReq = 0;
  bit          monOn = 1'b0;
  bit          respOn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one expected entry per instruction reaching MEM/WB (all use we=1).
  always @(negedge clk) begin
    if (monOn) begin
      if (stallMEM) seenStall++;
      if (mem_req) seenReq++;
      if (weOut) begin
        if (sbQ.size() == 0) begin
          check("unexpected_wb", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          check("wb_data", 32'(wb_dataOut), 32'(e.data));
          check("wb_dst", 32'(dst_addrOut), 32'(e.dst));
          check("wb_hlt", 32'(hltOut), 32'(e.hlt));
          check("mem_err", 32'(mem_errOut), 32'(e.err));
          check("wb_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Memory responder: checks the port per access, acks after waitCyc cycles,
  // and throws in stray acks while no request is outstanding.
  initial begin
    bit          inAcc;
    int unsigned cnt;
    acc_t        cur;
    inAcc = 1'b0;
    cnt = 0;
    cur = '{addr: '0, wdata: '0, wr: 1'b0, waitCyc: 0};
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (respOn && mem_req) begin
        if (!inAcc) begin
          inAcc = 1'b1;
          cnt = 0;
          if (accQ.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
          end else begin
            cur = accQ.pop_front();
          end
        end
        if (mem_addr !== cur.addr) check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        if (mem_wr !== cur.wr) check("mem_wr", 32'(mem_wr), 32'(cur.wr));
        if (cur.wr && mem_wdata !== cur.wdata)
          check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
        if (cnt == cur.waitCyc) begin
          mem_ack = 1'b1;
          if (cur.wr) begin
            devMem[mem_addr[3:0]] = mem_wdata;
            mem_rdata = DW'($urandom);
          end else begin
            mem_rdata = devMem[mem_addr[3:0]];
          end
        end
        cnt++;
      end else begin
        if (!mem_req) inAcc = 1'b0;
        if (respOn && $urandom_range(0, 9) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = DW'($urandom);
        end
      end
    end
  end

  // Issue one instruction: compute its expected result, then hold it until
  // the stage accepts it (stall low at a clock edge).
  task automatic issue(input bit ld, input bit st, input logic [DW-1:0] a,
                       input logic [DW-1:0] d, input logic [RW-1:0] dst,
                       input bit hlt, input int unsigned w);
    exp_t        e;
    int unsigned k, lat;
    bit          s, accepted;
    k = cyc;
    dst_addrIn = dst; weIn = 1'b1; mem_reIn = ld; mem_weIn = st;
    hltIn = hlt; aluResultIn = a; mem_dataIn = d;
    if (!(ld || st)) begin
      lat = 1;
      e.data = a;
    end else begin
      accQ.push_back('{addr: a, wdata: d, wr: st, waitCyc: w});
      if (w < TO) begin
        lat = 3 + w;
        expReq += w + 1;
        if (st) begin
          refMem[a[3:0]] = d;
          e.data = a;
        end else begin
          e.data = refMem[a[3:0]];
        end
      end else begin
        lat = TO + 2;
        expReq += TO;
        refErr = 1'b1;
        e.data = st ? a : '0;
      end
      expStall += lat - 1;
    end
    e.dst = dst; e.hlt = hlt; e.err = refErr; e.cyc = k + lat;
    sbQ.push_back(e);
    accepted = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      s = stallMEM;
      @(posedge clk);
      #1;
      if (!s) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    weIn = 1'b0; mem_reIn = 1'b0; mem_weIn = 1'b0; hltIn = 1'b0;
  endtask

  task automatic randInstr();
    int unsigned kind, w;
    logic [DW-1:0] a;
    kind = $urandom_range(0, 3);
    a = DW'($urandom);
    w = ($urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 4);
    case (kind)
      0, 1: issue(1'b0, 1'b0, a, DW'($urandom), RW'($urandom), bit'($urandom_range(0, 1)), 0);
      2: issue(1'b1, 1'b0, a, DW'($urandom), RW'($urandom), bit'($urandom_range(0, 1)), w);
      default: issue(bit'($urandom_range(0, 1)), 1'b1, a, DW'($urandom), RW'($urandom), 1'b0, w);
    endcase
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      refMem[i] = '0;
      devMem[i] = '0;
    end
    refMem[0] = 16'hBEEF;
    devMem[0] = 16'hBEEF;
    mem_reIn = 1'b1;
    #12;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_stall", 32'(stallMEM), 0);
    check("rst_outs", {16'(wb_dataOut), 12'(dst_addrOut), weOut, hltOut, mem_errOut, mem_wr}, 0);
    mem_reIn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    monOn = 1'b1;
    respOn = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 1'b0, 16'h1234, 16'h0, 4'h3, 1'b0, 0);
    issue(1'b1, 1'b0, 16'h0040, 16'h0, 4'h5, 1'b0, 0);
    issue(1'b0, 1'b1, 16'h0010, 16'hA5A5, 4'h6, 1'b0, 3);
    issue(1'b1, 1'b0, 16'h0030, 16'h0, 4'h7, 1'b0, 0);
    issue(1'b1, 1'b0, 16'h0000, 16'h0, 4'h8, 1'b0, TO - 1);
    for (int i = 0; i < 40; i++) randInstr();
    issue(1'b1, 1'b0, 16'h0020, 16'h0, 4'h9, 1'b0, NEVER);
    issue(1'b1, 1'b0, 16'h0010, 16'h0, 4'hA, 1'b1, 0);
    issue(1'b0, 1'b0, 16'h5678, 16'h0, 4'hB, 1'b0, 0);
    for (int i = 0; i < 30; i++) randInstr();

    respOn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sbQ.size(), 0);
    check("acc_empty", accQ.size(), 0);
    check("stall_cycles", seenStall, expStall);
    check("req_cycles", seenReq, expReq);
    monOn = 1'b0;

    // Reset during the second ACCESS cycle of a load.
    dst_addrIn = 4'hC; weIn = 1'b1; mem_reIn = 1'b1; aluResultIn = 16'h0044;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_req", 32'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(mem_req), 0);
    check("midrst_stall", 32'(stallMEM), 0);
    check("midrst_outs", {16'(wb_dataOut), 12'(dst_addrOut), weOut, hltOut, mem_errOut, mem_wr}, 0);
    check("midrst_addr", 32'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    weIn = 1'b1; mem_reIn = 1'b0; aluResultIn = 16'h0000; dst_addrIn = 4'h1;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      check("post_rst_req", 32'(mem_req), 0);
      check("post_rst_wb", 32'(wb_dataOut), 0);
      check("post_rst_err", 32'(mem_errOut), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
